// File: rtl/rv_pkg.sv
// Shared types for the rv core memory subsystem: data width, arbiter port IDs
// and the request record held in the arbiter's pending registers.
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_port_e;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic              we;
        logic [XLEN/8-1:0] be;
        logic [XLEN-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/rv_arb_id_fifo.sv
// Two-entry in-order FIFO of port IDs. It remembers which port issued each
// outstanding memory request so the responses can be routed back.
module rv_arb_id_fifo
    import rv_pkg::*;
(
    input  logic      clk_i,
    input  logic      arstn_i,
    input  logic      push_i,
    input  arb_port_e push_id_i,
    input  logic      pop_i,
    output arb_port_e head_o,
    output logic      empty_o,
    output logic      full_o
);

    arb_port_e  slot_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign head_o  = slot_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still accept a push when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            slot_q[0] <= ARB_INSTR;
            slot_q[1] <= ARB_INSTR;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one single-port memory between the instruction and data ports of
// rv_core: one-entry pending register per port, round-robin issue, in-order routing.
module rv_mem_arbiter
    import rv_pkg::*;
(
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              err_o
);

    logic            instr_pend_q;
    logic [XLEN-1:0] instr_addr_q;
    logic            data_pend_q;
    mem_req_t        data_req_q;
    logic            instr_outst_q;
    logic            data_outst_q;
    logic            data_store_q;
    arb_port_e       rr_last_q;
    logic            err_q;

    logic            grant_valid;
    arb_port_e       grant;
    logic            issue_instr;
    logic            issue_data;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;
    arb_port_e       fifo_head;
    logic            resp_instr;
    logic            resp_data;
    logic            instr_busy;
    logic            data_busy;
    logic            err_set;

    // On contention the port that did not win last time goes first.
    always_comb begin
        grant_valid = instr_pend_q || data_pend_q;
        grant       = ARB_DATA;
        if (instr_pend_q && data_pend_q) begin
            grant = (rr_last_q == ARB_DATA) ? ARB_INSTR : ARB_DATA;
        end else if (instr_pend_q) begin
            grant = ARB_INSTR;
        end
    end

    assign issue_instr = grant_valid && (grant == ARB_INSTR);
    assign issue_data  = grant_valid && (grant == ARB_DATA);

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (arstn_i && grant_valid) begin
            mem_req_o = 1'b1;
            if (grant == ARB_DATA) begin
                mem_we_o    = data_req_q.we;
                mem_be_o    = data_req_q.be;
                mem_addr_o  = data_req_q.addr;
                mem_wdata_o = data_req_q.wdata;
            end else begin
                mem_be_o   = '1;
                mem_addr_o = instr_addr_q;
            end
        end
    end

    rv_arb_id_fifo u_id_fifo (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .push_i    (grant_valid),
        .push_id_i (grant),
        .pop_i     (fifo_pop),
        .head_o    (fifo_head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign fifo_pop   = mem_rvalid_i && !fifo_empty;
    assign resp_instr = fifo_pop && (fifo_head == ARB_INSTR);
    assign resp_data  = fifo_pop && (fifo_head == ARB_DATA);

    // A port whose response returns this cycle is already idle, so it may re-request on the same edge.
    assign instr_busy = instr_pend_q || (instr_outst_q && !resp_instr);
    assign data_busy  = data_pend_q  || (data_outst_q  && !resp_data);

    assign err_set = (mem_rvalid_i && fifo_empty)
                   || (instr_req_i && instr_busy)
                   || (data_req_i && data_busy)
                   || (grant_valid && fifo_full && !fifo_pop);

    always_comb begin
        instr_rvalid_o = arstn_i && resp_instr;
        data_rvalid_o  = arstn_i && resp_data;
        instr_rdata_o  = '0;
        data_rdata_o   = '0;
        if (instr_rvalid_o) begin
            instr_rdata_o = mem_rdata_i;
        end
        if (data_rvalid_o && !data_store_q) begin
            data_rdata_o = mem_rdata_i;
        end
    end

    assign err_o = arstn_i && err_q;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            instr_pend_q  <= 1'b0;
            instr_addr_q  <= '0;
            data_pend_q   <= 1'b0;
            data_req_q    <= '0;
            instr_outst_q <= 1'b0;
            data_outst_q  <= 1'b0;
            data_store_q  <= 1'b0;
            rr_last_q     <= ARB_INSTR;
            err_q         <= 1'b0;
        end else begin
            if (issue_instr) begin
                instr_pend_q <= 1'b0;
            end else if (instr_req_i && !instr_busy) begin
                instr_pend_q <= 1'b1;
                instr_addr_q <= instr_addr_i;
            end
            if (issue_data) begin
                data_pend_q <= 1'b0;
            end else if (data_req_i && !data_busy) begin
                data_pend_q <= 1'b1;
                data_req_q  <= '{addr: data_addr_i, we: data_we_i, be: data_be_i, wdata: data_wdata_i};
            end
            if (issue_instr) begin
                instr_outst_q <= 1'b1;
            end else if (resp_instr) begin
                instr_outst_q <= 1'b0;
            end
            if (issue_data) begin
                data_outst_q <= 1'b1;
                data_store_q <= data_req_q.we;
            end else if (resp_data) begin
                data_outst_q <= 1'b0;
            end
            if (grant_valid) begin
                rr_last_q <= grant;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_rv_mem_arbiter;
    import rv_pkg::*;

    logic        clk_i;
    logic        arstn_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    rv_mem_arbiter dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .err_o          (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        mrv;
        logic [31:0] mrdata;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_mwe;
        logic [3:0]  e_mbe;
        logic [31:0] e_mwdata;
        logic        e_iv;
        logic [31:0] e_ir;
        logic        e_dv;
        logic [31:0] e_dr;
    } vec_t;

    vec_t        tbl [7];

    int          tests_run;
    int          tests_failed;
    int          cycle;

    // Transaction-level model: port 0 is instruction, port 1 is data.
    bit          m_pend [2];
    logic [31:0] m_addr [2];
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    int          m_inflight [$];
    bit          m_inflight_we [$];
    bit          m_prefer_data;
    bit          m_err;
    int          last_issue_port;

    int          mem_due [$];
    int          last_due;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checkOutput(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] daddr, input logic [31:0] dwdata,
                                 input logic mrv, input logic [31:0] mrdata);
        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        data_req_i   = dreq;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_addr_i  = daddr;
        data_wdata_i = dwdata;
        mem_rvalid_i = mrv;
        mem_rdata_i  = mrdata;
        #1;
    endtask

    task automatic idle_inputs();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic model_reset();
        m_pend[0]     = 1'b0;
        m_pend[1]     = 1'b0;
        m_inflight.delete();
        m_inflight_we.delete();
        m_prefer_data = 1'b1;
        m_err         = 1'b0;
        last_issue_port = -1;
    endtask

    // A port is free when it holds no pending request and none of its requests is in flight.
    function automatic bit port_free(input int p, input bit skip_head);
        if (m_pend[p]) return 1'b0;
        foreach (m_inflight[i]) begin
            if (m_inflight[i] == p && !(skip_head && i == 0)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        int          win = -1;
        int          resp = -1;
        bit          spurious = 1'b0;
        logic        e_req = 1'b0;
        logic        e_we = 1'b0;
        logic [3:0]  e_be = '0;
        logic [31:0] e_addr = '0;
        logic [31:0] e_wdata = '0;
        logic        e_iv = 1'b0;
        logic        e_dv = 1'b0;
        logic [31:0] e_ir = '0;
        logic [31:0] e_dr = '0;
        logic        e_err = 1'b0;
        if (arstn_i) begin
            if (m_pend[0] && m_pend[1]) win = m_prefer_data ? 1 : 0;
            else if (m_pend[1])         win = 1;
            else if (m_pend[0])         win = 0;
            if (win >= 0) begin
                e_req  = 1'b1;
                e_addr = m_addr[win];
                e_we   = (win == 1) ? m_we : 1'b0;
                e_be   = (win == 1) ? m_be : 4'hF;
                e_wdata = (win == 1) ? m_wdata : '0;
            end
            if (mem_rvalid_i) begin
                if (m_inflight.size() > 0) resp = m_inflight[0];
                else spurious = 1'b1;
            end
            e_iv = (resp == 0);
            e_dv = (resp == 1);
            if (e_iv) e_ir = mem_rdata_i;
            if (e_dv && !m_inflight_we[0]) e_dr = mem_rdata_i;
            e_err = m_err;
        end
        check_bit("mem_req", mem_req_o, e_req);
        checkOutput("mem_addr", mem_addr_o, e_addr);
        check_bit("mem_we", mem_we_o, e_we);
        checkOutput("mem_be", {28'b0, mem_be_o}, {28'b0, e_be});
        checkOutput("mem_wdata", mem_wdata_o, e_wdata);
        check_bit("instr_rvalid", instr_rvalid_o, e_iv);
        checkOutput("instr_rdata", instr_rdata_o, e_ir);
        check_bit("data_rvalid", data_rvalid_o, e_dv);
        checkOutput("data_rdata", data_rdata_o, e_dr);
        check_bit("err", err_o, e_err);
        if (!arstn_i) begin
            model_reset();
            return;
        end
        if (spurious) m_err = 1'b1;
        if (resp >= 0) begin
            void'(m_inflight.pop_front());
            void'(m_inflight_we.pop_front());
        end
        if (instr_req_i) begin
            if (port_free(0, 1'b0)) begin
                m_pend[0] = 1'b1;
                m_addr[0] = instr_addr_i;
            end else begin
                m_err = 1'b1;
            end
        end
        if (data_req_i) begin
            if (port_free(1, 1'b0)) begin
                m_pend[1] = 1'b1;
                m_addr[1] = data_addr_i;
                m_we      = data_we_i;
                m_be      = data_be_i;
                m_wdata   = data_wdata_i;
            end else begin
                m_err = 1'b1;
            end
        end
        last_issue_port = win;
        if (win >= 0) begin
            m_pend[win] = 1'b0;
            m_inflight.push_back(win);
            m_inflight_we.push_back(win == 1 && m_we);
            m_prefer_data = (win == 0);
        end
    endtask

    task automatic step_cycle();
        model_step();
        @(posedge clk_i);
        #1;
        cycle++;
    endtask

    task automatic do_reset(input int n);
        arstn_i = 1'b0;
        repeat (n) begin
            idle_inputs();
            step_cycle();
        end
        arstn_i = 1'b1;
        mem_due.delete();
        last_due = -1;
    endtask

    // Memory responder with in-order, per-request latency; cores request only when free.
    task automatic run_traffic(input int n, input int lat_min, input int lat_max,
                               input bit continuous, input bit check_rr);
        bit exp_port = 1'b1;
        int grants = 0;
        for (int k = 0; k < n; k++) begin
            bit mrv;
            bit ireq;
            bit dreq;
            int issue_cycle;
            int due;
            mrv = (mem_due.size() > 0) && (mem_due[0] <= cycle);
            if (mrv) void'(mem_due.pop_front());
            ireq = port_free(0, mrv) && (continuous || ($urandom_range(0, 1) == 1));
            dreq = port_free(1, mrv) && (continuous || ($urandom_range(0, 1) == 1));
            applyStimulus(ireq, {16'h1000, 16'($urandom)}, dreq, 1'($urandom),
                          4'($urandom_range(1, 15)), {16'h2000, 16'($urandom)},
                          $urandom, mrv, $urandom);
            if (check_rr && mem_req_o) begin
                check_bit("rr_grant_port", mem_addr_o[31:16] == 16'h2000, exp_port);
                exp_port = ~exp_port;
                grants++;
            end
            issue_cycle = cycle;
            step_cycle();
            if (last_issue_port >= 0) begin
                due = issue_cycle + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                mem_due.push_back(due);
                last_due = due;
            end
        end
        if (check_rr) check_bit("rr_grant_count", grants >= n - 2, 1'b1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cycle        = 0;
        arstn_i      = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_due.delete();
        last_due     = -1;

        tbl[0] = '{1'b1, 32'h40, 1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEADBEEF, 1'b0, '0,
                   1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0};
        tbl[1] = '{1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0,
                   1'b1, 32'h2000, 1'b1, 4'h3, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0};
        tbl[2] = '{1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h12345678,
                   1'b1, 32'h40, 1'b0, 4'hF, '0, 1'b0, '0, 1'b1, '0};
        tbl[3] = '{1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h13,
                   1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h13, 1'b0, '0};
        tbl[4] = '{1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h3000, '0, 1'b0, '0,
                   1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0};
        tbl[5] = '{1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0,
                   1'b1, 32'h3000, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, '0};
        tbl[6] = '{1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'hCAFEF00D,
                   1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'hCAFEF00D};

        @(posedge clk_i);
        #1;
        do_reset(2);

        // Lone instruction fetch, memory latency 1.
        idle_inputs();
        check_bit("reset_mem_req", mem_req_o, 1'b0);
        check_bit("reset_err", err_o, 1'b0);
        step_cycle();
        applyStimulus(1'b1, 32'h100dc, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        check_bit("fetch_not_early", mem_req_o, 1'b0);
        step_cycle();
        idle_inputs();
        check_bit("fetch_mem_req", mem_req_o, 1'b1);
        checkOutput("fetch_mem_addr", mem_addr_o, 32'h100dc);
        check_bit("fetch_mem_we", mem_we_o, 1'b0);
        checkOutput("fetch_mem_be", {28'b0, mem_be_o}, 32'hF);
        step_cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h00000013);
        check_bit("fetch_rvalid", instr_rvalid_o, 1'b1);
        checkOutput("fetch_rdata", instr_rdata_o, 32'h13);
        check_bit("fetch_no_data_rvalid", data_rvalid_o, 1'b0);
        step_cycle();

        // Simultaneous requests, store response, then a load.
        do_reset(1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, tbl[i].dwe, tbl[i].dbe,
                          tbl[i].daddr, tbl[i].dwdata, tbl[i].mrv, tbl[i].mrdata);
            check_bit($sformatf("vec%0d_mem_req", i), mem_req_o, tbl[i].e_mreq);
            checkOutput($sformatf("vec%0d_mem_addr", i), mem_addr_o, tbl[i].e_maddr);
            check_bit($sformatf("vec%0d_mem_we", i), mem_we_o, tbl[i].e_mwe);
            checkOutput($sformatf("vec%0d_mem_be", i), {28'b0, mem_be_o}, {28'b0, tbl[i].e_mbe});
            checkOutput($sformatf("vec%0d_mem_wdata", i), mem_wdata_o, tbl[i].e_mwdata);
            check_bit($sformatf("vec%0d_instr_rvalid", i), instr_rvalid_o, tbl[i].e_iv);
            checkOutput($sformatf("vec%0d_instr_rdata", i), instr_rdata_o, tbl[i].e_ir);
            check_bit($sformatf("vec%0d_data_rvalid", i), data_rvalid_o, tbl[i].e_dv);
            checkOutput($sformatf("vec%0d_data_rdata", i), data_rdata_o, tbl[i].e_dr);
            step_cycle();
        end

        // Busy-port request while a fetch is outstanding.
        do_reset(1);
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        step_cycle();
        idle_inputs();
        check_bit("busy_first_issue", mem_req_o, 1'b1);
        step_cycle();
        applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        check_bit("busy_err_before", err_o, 1'b0);
        step_cycle();
        idle_inputs();
        check_bit("busy_err_set", err_o, 1'b1);
        check_bit("busy_no_extra_req", mem_req_o, 1'b0);
        step_cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h77);
        check_bit("busy_orig_rvalid", instr_rvalid_o, 1'b1);
        checkOutput("busy_orig_rdata", instr_rdata_o, 32'h77);
        step_cycle();
        idle_inputs();
        check_bit("busy_no_req_after", mem_req_o, 1'b0);
        check_bit("busy_err_sticky", err_o, 1'b1);
        step_cycle();

        // Spurious memory response with nothing outstanding.
        do_reset(1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h99);
        check_bit("spur_no_instr_rvalid", instr_rvalid_o, 1'b0);
        check_bit("spur_no_data_rvalid", data_rvalid_o, 1'b0);
        step_cycle();
        idle_inputs();
        check_bit("spur_err_set", err_o, 1'b1);
        step_cycle();
        idle_inputs();
        check_bit("spur_err_sticky", err_o, 1'b1);
        step_cycle();

        // Reset while a data load is pending.
        do_reset(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h4000, '0, 1'b0, '0);
        step_cycle();
        arstn_i = 1'b0;
        idle_inputs();
        check_bit("rst_mem_req_gated", mem_req_o, 1'b0);
        step_cycle();
        arstn_i = 1'b1;
        mem_due.delete();
        last_due = -1;
        idle_inputs();
        check_bit("rst_after_mem_req", mem_req_o, 1'b0);
        check_bit("rst_after_err", err_o, 1'b0);
        step_cycle();
        applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        step_cycle();
        idle_inputs();
        check_bit("rst_next_fetch_req", mem_req_o, 1'b1);
        checkOutput("rst_next_fetch_addr", mem_addr_o, 32'h700);
        step_cycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h1234);
        check_bit("rst_next_fetch_rvalid", instr_rvalid_o, 1'b1);
        check_bit("rst_next_fetch_err", err_o, 1'b0);
        step_cycle();

        // Round-robin fairness under continuous requests, latency 1.
        do_reset(1);
        run_traffic(20, 1, 1, 1'b1, 1'b1);

        // Both ports outstanding with memory latency 3.
        do_reset(1);
        run_traffic(40, 3, 3, 1'b1, 1'b0);

        // Random legal traffic with variable latency.
        do_reset(1);
        run_traffic(400, 1, 4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
